// File: rtl/lift_step_core.sv
// LeGall 5/3 lifting step (forward/inverse predict and update) with a registered result.
// Define LIFT_STEP_PIPE_EN for a two-stage pipelined variant with 2-cycle latency.
module lift_step_core #(
    parameter int unsigned DW = 15,
    parameter int unsigned RW = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic signed [DW-1:0] left_i,
    input  logic signed [DW-1:0] sam_i,
    input  logic signed [DW-1:0] right_i,
    input  logic [3:0]           flgs_i,
    input  logic                 update_i,
    output logic signed [RW-1:0] res_o,
    output logic                 update_o
);

    localparam logic [2:0] OpPass    = 3'd0;
    localparam logic [2:0] OpFwdPred = 3'd1;
    localparam logic [2:0] OpInvPred = 3'd2;
    localparam logic [2:0] OpFwdUpd  = 3'd3;
    localparam logic [2:0] OpInvUpd  = 3'd4;

    logic signed [RW-1:0] s_d;
    logic signed [RW-1:0] sam_d;
    logic [2:0]           op_d;

    assign s_d   = RW'(left_i) + RW'(right_i);
    assign sam_d = RW'(sam_i);

    always_comb begin
        op_d = OpPass;
        case (flgs_i)
            4'b0111: op_d = OpFwdPred;
            4'b0101: op_d = OpInvPred;
            4'b0110: op_d = OpFwdUpd;
            4'b0100: op_d = OpInvUpd;
            default: op_d = OpPass;
        endcase
    end

    // Operands seen by the arithmetic stage and the valid that loads res_o.
    logic signed [RW-1:0] s_e;
    logic signed [RW-1:0] sam_e;
    logic [2:0]           op_e;
    logic                 stage_v;

`ifdef LIFT_STEP_PIPE_EN
    logic signed [RW-1:0] s_q;
    logic signed [RW-1:0] sam_q;
    logic [2:0]           op_q;
    logic                 vld_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q   <= '0;
            sam_q <= '0;
            op_q  <= OpPass;
            vld_q <= 1'b0;
        end else begin
            vld_q <= update_i;
            if (update_i) begin
                s_q   <= s_d;
                sam_q <= sam_d;
                op_q  <= op_d;
            end
        end
    end

    assign s_e     = s_q;
    assign sam_e   = sam_q;
    assign op_e    = op_q;
    assign stage_v = vld_q;
`else
    assign s_e     = s_d;
    assign sam_e   = sam_d;
    assign op_e    = op_d;
    assign stage_v = update_i;
`endif

    logic signed [RW-1:0] half;
    logic signed [RW-1:0] half_rnd;
    logic signed [RW-1:0] quarter;
    logic signed [RW-1:0] res_c;

    // floor((s+2)/4) == floor((floor(s/2)+1)/2); keeps every term inside RW bits.
    assign half     = s_e >>> 1;
    assign half_rnd = half + $signed({{(RW-1){1'b0}}, 1'b1});
    assign quarter  = half_rnd >>> 1;

    always_comb begin
        res_c = sam_e;
        case (op_e)
            OpFwdPred: res_c = sam_e - half;
            OpInvPred: res_c = sam_e + half;
            OpFwdUpd:  res_c = sam_e + quarter;
            OpInvUpd:  res_c = sam_e - quarter;
            default:   res_c = sam_e;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_o    <= '0;
            update_o <= 1'b0;
        end else begin
            update_o <= stage_v;
            if (stage_v) begin
                res_o <= res_c;
            end
        end
    end

endmodule

// File: tb/tb_lift_step_core.sv
// Self-checking bench for lift_step_core: integer reference model plus directed vectors.
// Honours LIFT_STEP_PIPE_EN to select the expected latency.
module tb_lift_step_core;

`ifdef LIFT_STEP_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic               clk;
    logic               rst_n;
    logic signed [14:0] left_i;
    logic signed [14:0] sam_i;
    logic signed [14:0] right_i;
    logic [3:0]         flgs_i;
    logic               update_i;
    logic signed [15:0] res_o;
    logic               update_o;

    int total = 0;
    int bad   = 0;
    int upd_cnt = 0;

    lift_step_core #(
        .DW(15),
        .RW(16)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .left_i  (left_i),
        .sam_i   (sam_i),
        .right_i (right_i),
        .flgs_i  (flgs_i),
        .update_i(update_i),
        .res_o   (res_o),
        .update_o(update_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic signed [31:0] got,
                         input logic signed [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    function automatic int fdiv(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    function automatic int ref_lift(input int l, input int s, input int r, input int f);
        int sum;
        sum = l + r;
        case (f)
            7:       return s - fdiv(sum, 2);
            5:       return s + fdiv(sum, 2);
            6:       return s + fdiv(sum + 2, 4);
            4:       return s - fdiv(sum + 2, 4);
            default: return s;
        endcase
    endfunction

    // Model: a LAT-deep delay line of (valid, value); output value holds between valids.
    bit mv [0:1];
    int mr [0:1];
    bit exp_v = 1'b0;
    int exp_r = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mv[i] = 1'b0;
                mr[i] = 0;
            end
            exp_v = 1'b0;
            exp_r = 0;
        end else begin
            for (int i = LAT - 1; i > 0; i--) begin
                mv[i] = mv[i-1];
                mr[i] = mr[i-1];
            end
            mv[0] = update_i;
            mr[0] = ref_lift(int'(left_i), int'(sam_i), int'(right_i), int'(flgs_i));
            exp_v = mv[LAT-1];
            if (exp_v) exp_r = mr[LAT-1];
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("cmp_update_o", update_o, exp_v);
            check("cmp_res_o", res_o, exp_r);
        end else begin
            check("cmp_rst_update_o", update_o, 0);
            check("cmp_rst_res_o", res_o, 0);
        end
        if (update_o === 1'b1) upd_cnt++;
    end

    task automatic set_in(input int l, input int s, input int r, input int f, input bit u);
        left_i   = 15'(l);
        sam_i    = 15'(s);
        right_i  = 15'(r);
        flgs_i   = 4'(f);
        update_i = u;
    endtask

    task automatic pulse(input string name, input int l, input int s, input int r,
                         input int f, input int want);
        @(posedge clk); #2;
        set_in(l, s, r, f, 1'b1);
        @(posedge clk); #2;
        update_i = 1'b0;
        repeat (LAT - 1) @(posedge clk);
        @(negedge clk);
        check({name, "_res"}, res_o, want);
        check({name, "_vld"}, update_o, 1);
        @(negedge clk);
        check({name, "_vld_off"}, update_o, 0);
    endtask

    int fseq [0:3] = '{7, 6, 5, 4};

    initial begin
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 1'b0);

        // Pin the reference model to hand-computed values.
        check("model_fp", ref_lift(10, 100, 20, 7), 85);
        check("model_fu_neg", ref_lift(-3, 0, -4, 6), -2);
        check("model_ext", ref_lift(-16384, 16383, -16384, 7), 32767);

        // Reset held with live strobe and random data.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #2;
            set_in(int'(15'($urandom)), int'(15'($urandom)), int'(15'($urandom)),
                   int'(4'($urandom)), 1'b1);
            @(negedge clk);
            check("rst_res", res_o, 0);
            check("rst_vld", update_o, 0);
        end

        // Release with a valid operation already presented.
        @(posedge clk); #2;
        rst_n = 1'b1;
        set_in(10, 100, 20, 7, 1'b1);
        @(posedge clk); #2;
        update_i = 1'b0;
        repeat (LAT - 1) @(posedge clk);
        @(negedge clk);
        check("first_res", res_o, 85);
        check("first_vld", update_o, 1);
        repeat (2) @(negedge clk);

        pulse("fwd_pred", 10, 100, 20, 7, 85);
        pulse("inv_pred", 10, 100, 20, 5, 115);
        pulse("fwd_upd", 10, 100, 20, 6, 108);
        pulse("inv_upd", 10, 100, 20, 4, 92);
        pulse("neg_fp", -3, 0, -4, 7, 4);
        pulse("neg_fu", -3, 0, -4, 6, -2);
        pulse("ext_ip", 16383, -16384, 16383, 5, -1);
        pulse("ext_fp", 16383, -16384, 16383, 7, -32767);
        pulse("ext_max", -16384, 16383, -16384, 7, 32767);
        pulse("pass_f", 50, -5, 60, 15, -5);

        // Hold: no strobe while inputs keep changing.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #2;
            set_in(i * 100, 1234 + i, -i * 50, 7, 1'b0);
            @(negedge clk);
            check("hold_res", res_o, -5);
            check("hold_vld", update_o, 0);
        end

        // Reset asserted while a result is in flight.
        @(posedge clk); #2;
        set_in(10, 100, 20, 6, 1'b1);
        @(posedge clk); #2;
        update_i = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        check("midrst_res", res_o, 0);
        check("midrst_vld", update_o, 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("postrst_vld", update_o, 0);
        end

        // Streaming: 8 back-to-back operations.
        upd_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #2;
            set_in(i * 5 - 20, 1000 + i * 37, 300 - i * 11, fseq[i % 4], 1'b1);
        end
        @(posedge clk); #2;
        update_i = 1'b0;
        repeat (LAT + 3) @(negedge clk);
        check("stream_count", upd_cnt, 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
